// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-port integer register file for the ID stage. It has combinational
//   read ports with optional same-cycle write-through bypass. It also keeps a
//   per-register busy scoreboard, which the hazard unit uses to stall on
//   sources that still have a producer in flight.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; clears registers and busy bits
//   rd_addr    in   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//   rd_data    out  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   rd_busy    out  NUM_RD       source of port i has a pending producer
//   wr_en      in   NUM_WR       write enable per write port
//   wr_addr    in   NUM_WR*AW    write destination per port
//   wr_data    in   NUM_WR*XLEN  write data per port
//   iss_valid  in   1            instruction issued with a destination
//   iss_rd     in   AW           destination marked busy on issue
//   busy_vec   out  NUM_REGS     registered scoreboard, bit r = reg r pending
//
// Register 0 is hardwired to zero and is never busy.
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_rd,
    output logic [NUM_REGS-1:0]      busy_vec
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]           busy_q, busy_d;

    logic [AW-1:0]   wr_addr_a [NUM_WR];
    logic [XLEN-1:0] wr_data_a [NUM_WR];

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
        assign wr_addr_a[w] = wr_addr[w*AW +: AW];
        assign wr_data_a[w] = wr_data[w*XLEN +: XLEN];
    end

    // Next state for the array and the scoreboard. The write ports are
    // walked in ascending order, so the highest-index port wins when two
    // ports collide. The issue mark is applied after the writeback clears.
    // That lets a newer producer keep the register busy when it issues in
    // the same cycle that the older one writes back.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (reset) begin
            regs_d = '0;
            busy_d = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr_a[w] != '0)) begin
                    regs_d[wr_addr_a[w]] = wr_data_a[w];
                    busy_d[wr_addr_a[w]] = 1'b0;
                end
            end
            if (iss_valid) begin
                busy_d[iss_rd] = 1'b1;
            end
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            hit;

        assign addr = rd_addr[i*AW +: AW];

        // A write-through hit also hides the busy bit. The value the reader
        // waits for is already on this port, so it does not need to stall.
        // Bypass is held off during reset because that write never commits.
        always_comb begin
            data = regs_q[addr];
            hit  = 1'b0;
            if (BYP_EN && !reset && (addr != '0)) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wr_addr_a[w] == addr)) begin
                        data = wr_data_a[w];
                        hit  = 1'b1;
                    end
                end
            end
            if (addr == '0) begin
                data = '0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy_q[addr] && !hit;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 3;
    localparam int NWR  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic [NRD-1:0][AW-1:0]    rd_a;
    logic [NWR-1:0]            we;
    logic [NWR-1:0][AW-1:0]    wr_a;
    logic [NWR-1:0][XLEN-1:0]  wr_d;
    logic                      iss_v;
    logic [AW-1:0]             iss_r;

    logic [NRD-1:0][XLEN-1:0]  rd_d1, rd_d0;
    logic [NRD-1:0]            rb1, rb0;
    logic [NR-1:0]             bv1, bv0;

    regfile_mp_sb #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut_byp (
        .clk(clk), .reset(rst), .rd_addr(rd_a), .rd_data(rd_d1), .rd_busy(rb1),
        .wr_en(we), .wr_addr(wr_a), .wr_data(wr_d), .iss_valid(iss_v), .iss_rd(iss_r),
        .busy_vec(bv1));

    regfile_mp_sb #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_nob (
        .clk(clk), .reset(rst), .rd_addr(rd_a), .rd_data(rd_d0), .rd_busy(rb0),
        .wr_en(we), .wr_addr(wr_a), .wr_data(wr_d), .iss_valid(iss_v), .iss_rd(iss_r),
        .busy_vec(bv0));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [XLEN-1:0] m_regs [NR];
    logic            m_busy [NR];

    typedef struct {
        logic [NRD-1:0][XLEN-1:0] d1;
        logic [NRD-1:0]           b1;
        logic [NRD-1:0][XLEN-1:0] d0;
        logic [NRD-1:0]           b0;
        logic [NR-1:0]            bv;
    } exp_t;

    exp_t sb_q[$];

    task automatic model_read(input bit byp, input logic [AW-1:0] a,
                              output logic [XLEN-1:0] d, output logic b);
        logic h;
        h = 1'b0;
        d = m_regs[a];
        if (byp && !rst) begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && wr_a[w] == a) begin
                    d = wr_d[w];
                    h = 1'b1;
                end
            end
        end
        b = m_busy[a] && !h;
        if (a == '0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && wr_a[w] != '0) begin
                    m_regs[wr_a[w]] = wr_d[w];
                    m_busy[wr_a[w]] = 1'b0;
                end
            end
            if (iss_v && iss_r != '0) m_busy[iss_r] = 1'b1;
        end
    endtask

    // Called at a negedge with inputs already driven. It pushes the
    // expectation for the current inputs and compares it against the DUT
    // outputs. It then advances the model across the next posedge and
    // returns at the following negedge.
    task automatic cycle();
        exp_t e, g;
        #1;
        for (int i = 0; i < NRD; i++) begin
            model_read(1'b1, rd_a[i], e.d1[i], e.b1[i]);
            model_read(1'b0, rd_a[i], e.d0[i], e.b0[i]);
        end
        for (int r = 0; r < NR; r++) e.bv[r] = m_busy[r];
        sb_q.push_back(e);
        g = sb_q.pop_front();
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("sb_rd_data_byp[%0d]", i), rd_d1[i], g.d1[i]);
            chk($sformatf("sb_rd_data_nob[%0d]", i), rd_d0[i], g.d0[i]);
        end
        chk("sb_rd_busy_byp", 32'(rb1), 32'(g.b1));
        chk("sb_rd_busy_nob", 32'(rb0), 32'(g.b0));
        chk("sb_busy_vec_byp", bv1, g.bv);
        chk("sb_busy_vec_nob", bv0, g.bv);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        rst   = 1'b0;
        we    = '0;
        wr_a  = '0;
        wr_d  = '0;
        iss_v = 1'b0;
        iss_r = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = 'x;
            m_busy[r] = 1'bx;
        end
        idle();
        rd_a = '0;
        rst  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        model_clock();
        @(negedge clk);

        // Reset clears junk
        idle();
        we[0] = 1'b1; wr_a[0] = 5'd5; wr_d[0] = 32'h5A5A_0F0F;
        iss_v = 1'b1; iss_r = 5'd4;
        cycle();
        idle(); rst = 1'b1;
        cycle();
        idle();
        rd_a[0] = 5'd5; rd_a[1] = 5'd4; rd_a[2] = 5'd0;
        #1;
        chk("rst_rd_x5", rd_d1[0], 32'h0);
        chk("rst_busy_vec", bv1, 32'h0);
        cycle();

        // Basic write, x0 hardwired
        idle(); we[0] = 1'b1; wr_a[0] = 5'd5; wr_d[0] = 32'hDEAD_BEEF;
        cycle();
        idle(); rd_a[0] = 5'd5;
        #1;
        chk("rd_x5_byp", rd_d1[0], 32'hDEAD_BEEF);
        chk("rd_x5_nob", rd_d0[0], 32'hDEAD_BEEF);
        cycle();
        idle(); we[0] = 1'b1; wr_a[0] = 5'd0; wr_d[0] = 32'h1; rd_a[0] = 5'd0;
        #1;
        chk("rd_x0_wr_same", rd_d1[0], 32'h0);
        cycle();
        idle(); rd_a[0] = 5'd0;
        #1;
        chk("rd_x0_after", rd_d1[0], 32'h0);
        chk("busy0", 32'(bv1[0]), 32'h0);
        cycle();

        // Same-cycle write/read bypass
        idle(); we[0] = 1'b1; wr_a[0] = 5'd7; wr_d[0] = 32'h1234; rd_a[1] = 5'd7;
        #1;
        chk("byp_x7", rd_d1[1], 32'h1234);
        chk("byp_x7_busy", 32'(rb1[1]), 32'h0);
        chk("nob_x7_old", rd_d0[1], 32'h0);
        cycle();
        idle(); rd_a[1] = 5'd7;
        #1;
        chk("nob_x7_new", rd_d0[1], 32'h1234);
        cycle();

        // Scoreboard
        idle(); iss_v = 1'b1; iss_r = 5'd3;
        cycle();
        idle(); rd_a[0] = 5'd3;
        #1;
        chk("sb_busy3_set", 32'(bv1[3]), 32'h1);
        chk("sb_rdbusy3_byp", 32'(rb1[0]), 32'h1);
        chk("sb_rdbusy3_nob", 32'(rb0[0]), 32'h1);
        cycle();
        idle(); rd_a[0] = 5'd3; we[1] = 1'b1; wr_a[1] = 5'd3; wr_d[1] = 32'h33;
        #1;
        chk("sb_wb3_byp_busy", 32'(rb1[0]), 32'h0);
        chk("sb_wb3_nob_busy", 32'(rb0[0]), 32'h1);
        cycle();
        idle();
        #1;
        chk("sb_busy3_clr", 32'(bv1[3]), 32'h0);
        cycle();
        idle(); iss_v = 1'b1; iss_r = 5'd3;
        cycle();
        idle(); iss_v = 1'b1; iss_r = 5'd3; we[0] = 1'b1; wr_a[0] = 5'd3; wr_d[0] = 32'h44;
        cycle();
        idle();
        #1;
        chk("sb_iss_wb_same", 32'(bv1[3]), 32'h1);
        chk("sb_iss_wb_same_nob", 32'(bv0[3]), 32'h1);
        cycle();

        // Two write ports to the same register
        idle(); we = 2'b11; wr_a[0] = 5'd9; wr_a[1] = 5'd9;
        wr_d[0] = 32'hA; wr_d[1] = 32'hB; rd_a[2] = 5'd9;
        #1;
        chk("dual_wr_byp", rd_d1[2], 32'hB);
        cycle();
        idle(); rd_a[2] = 5'd9;
        #1;
        chk("dual_wr_arr", rd_d0[2], 32'hB);
        cycle();

        // Random traffic with occasional resets
        for (int n = 0; n < 10000; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NRD; i++)
                rd_a[i] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            for (int w = 0; w < NWR; w++) begin
                we[w]   = ($urandom_range(0, 2) == 0);
                wr_a[w] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wr_d[w] = $urandom;
            end
            iss_v = ($urandom_range(0, 2) == 0);
            iss_r = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
